// File: rtl/iiie_branch_resolve.sv
// Branch resolve stage: registers adder results, detects mispredicts, issues redirect and BTB update.
// Optional BRANCH_STATS_EN adds branch and mispredict counters.
module iiie_branch_resolve #(
  parameter int unsigned ROB_W     = 6,
  parameter int unsigned PRF_W     = 6,
  parameter int unsigned UPD_DEPTH = 2
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_resetn_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [ROB_W-1:0] rob_id_i,
  input  logic [PRF_W-1:0] dest_i,
  input  logic             wr_en_i,
  input  logic             is_cf_i,
  input  logic [29:0]      pc_i,
  input  logic             brnch_res_i,
  input  logic [1:0]       branch_type_i,
  input  logic [31:0]      excp_addr_i,
  input  logic [31:0]      result_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  output logic             wb_valid_o,
  output logic [ROB_W-1:0] wb_rob_o,
  output logic [PRF_W-1:0] wb_dest_o,
  output logic [31:0]      wb_data_o,
  output logic             wb_wen_o,
  output logic             redir_valid_o,
  output logic [31:0]      redir_target_o,
  output logic [ROB_W-1:0] redir_rob_o,
  input  logic             redir_ready_i,
  output logic             upd_valid_o,
  output logic [29:0]      upd_pc_o,
  output logic [31:0]      upd_target_o,
  output logic             upd_taken_o,
  output logic [1:0]       upd_type_o,
  input  logic             upd_ready_i,
  output logic             busy_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches_o,
  output logic [31:0]      stat_mispred_o
`endif
);

  localparam int unsigned PtrW = $clog2(UPD_DEPTH);
  localparam int unsigned CntW = $clog2(UPD_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRedir, StWaitFlush} state_e;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  btype;
  } upd_t;

  state_e           state_q;
  logic             redir_valid_q;
  logic [31:0]      redir_target_q;
  logic [ROB_W-1:0] redir_rob_q;
  logic             wb_valid_q, wb_wen_q;
  logic [ROB_W-1:0] wb_rob_q;
  logic [PRF_W-1:0] wb_dest_q;
  logic [31:0]      wb_data_q;
  upd_t             fifo_q [UPD_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic taken, mispredict, push, pop, fifo_full, fifo_empty, start_redir;

  always_comb begin
    taken       = (branch_type_i == 2'b00) ? brnch_res_i : 1'b1;
    mispredict  = is_cf_i & ((taken != pred_taken_i) | (taken & (excp_addr_i != pred_target_i)));
    fifo_full   = (count_q == CntW'(UPD_DEPTH));
    fifo_empty  = (count_q == '0);
    push        = valid_i & is_cf_i & (state_q == StIdle) & ~flush_i;
    pop         = ~fifo_empty & upd_ready_i;
    start_redir = valid_i & mispredict & (state_q == StIdle) & ~flush_i;
  end

  // Writeback runs in every state; only a same-cycle flush suppresses it.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_rob_q   <= '0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= valid_i & ~flush_i;
      if (valid_i) begin
        wb_wen_q  <= wr_en_i;
        wb_rob_q  <= rob_id_i;
        wb_dest_q <= dest_i;
        wb_data_q <= result_i;
      end
    end
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      state_q        <= StIdle;
      redir_valid_q  <= 1'b0;
      redir_target_q <= '0;
      redir_rob_q    <= '0;
    end else if (flush_i) begin
      state_q       <= StIdle;
      redir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_redir) begin
            state_q        <= StRedir;
            redir_valid_q  <= 1'b1;
            redir_target_q <= excp_addr_i;
            redir_rob_q    <= rob_id_i;
          end
        end
        StRedir: begin
          if (redir_valid_q && redir_ready_i) begin
            state_q       <= StWaitFlush;
            redir_valid_q <= 1'b0;
          end
        end
        StWaitFlush: state_q <= StWaitFlush;
        default: begin
          state_q       <= StIdle;
          redir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Flush leaves the FIFO intact: its entries belong to older, committed-path ops.
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      for (int i = 0; i < int'(UPD_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{pc: pc_i, target: excp_addr_i, taken: taken, btype: branch_type_i};
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_mispred_q;

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (push)        stat_branches_q <= stat_branches_q + 32'd1;
      if (start_redir) stat_mispred_q  <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`endif

  assign wb_valid_o     = wb_valid_q;
  assign wb_rob_o       = wb_rob_q;
  assign wb_dest_o      = wb_dest_q;
  assign wb_data_o      = wb_data_q;
  assign wb_wen_o       = wb_wen_q;
  assign redir_valid_o  = redir_valid_q;
  assign redir_target_o = redir_target_q;
  assign redir_rob_o    = redir_rob_q;
  assign upd_valid_o    = ~fifo_empty;
  assign upd_pc_o       = fifo_q[rd_ptr_q].pc;
  assign upd_target_o   = fifo_q[rd_ptr_q].target;
  assign upd_taken_o    = fifo_q[rd_ptr_q].taken;
  assign upd_type_o     = fifo_q[rd_ptr_q].btype;
  assign busy_o         = (state_q != StIdle) | fifo_full;

  // Issue must honour busy_o; a push into a full FIFO without a pop would drop an entry.
  push_when_full_a: assert property (@(posedge cpu_clock_i) disable iff (!cpu_resetn_i)
                                     !(push && fifo_full && !pop));

endmodule

// File: doc/iiie_branch_resolve.md
Name: iiie_branch_resolve

Overview:
- Stage directly downstream of the integer-execute branch/AUIPC adder.
- Registers the adder's resolved direction, type, target and link/AUIPC result, compares them against the frontend prediction, and produces three outputs:
  - register writeback;
  - a single frontend redirect on mispredict;
  - a queued BTB/RAS training update.
- After a mispredict it squashes younger branches until the core flush arrives.

Parameters:
- ROB_W, 6, width of ROB tag.
- PRF_W, 6, width of physical destination tag.
- UPD_DEPTH, 2, depth of BTB-update FIFO (power of 2, ≥2).

Ports:
- cpu_clock_i  in  1  core clock
- cpu_resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  core pipeline flush
- valid_i  in  1  branch-unit op valid this cycle
- rob_id_i  in  ROB_W  ROB tag of op
- dest_i  in  PRF_W  destination phys reg
- wr_en_i  in  1  op writes rd (jal/jalr/auipc with rd≠x0)
- is_cf_i  in  1  op is control flow (branch/jal/jalr; 0 for auipc)
- pc_i  in  30  word PC of op
- brnch_res_i  in  1  resolved taken (conditional)
- branch_type_i  in  2  00 cond, 01 call, 10 jump, 11 ret
- excp_addr_i  in  32  resolved next PC
- result_i  in  32  link/AUIPC value
- pred_taken_i  in  1  frontend predicted taken
- pred_target_i  in  32  frontend predicted target
- wb_valid_o  out  1  writeback valid
- wb_rob_o  out  ROB_W  writeback ROB tag
- wb_dest_o  out  PRF_W  writeback dest
- wb_data_o  out  32  writeback data
- wb_wen_o  out  1  writes register file
- redir_valid_o  out  1  redirect request
- redir_target_o  out  32  redirect PC
- redir_rob_o  out  ROB_W  ROB tag of mispredicting op
- redir_ready_i  in  1  frontend accepts redirect
- upd_valid_o  out  1  BTB update valid
- upd_pc_o  out  30  branch word PC
- upd_target_o  out  32  resolved target
- upd_taken_o  out  1  resolved direction
- upd_type_o  out  2  branch type
- upd_ready_i  in  1  BTB accepts update
- busy_o  out  1  stalls issue (FSM not IDLE or FIFO full)

Behaviour:
- Reset: every output 0, FSM=IDLE, FIFO empty.
- Taken definition: taken = brnch_res_i when branch_type_i==00, else 1.
- Mispredict = is_cf_i & (taken≠pred_taken_i | (taken & excp_addr_i≠pred_target_i)).
- Writeback:
  - Registered one cycle after valid_i with all wb_* fields; wb_valid_o is a single-cycle pulse.
  - wb_data_o = result_i.
  - Writeback is issued in every FSM state; the ROB handles ordering.
  - flush_i in the same cycle suppresses it.
- FSM:
  - IDLE:
    - valid_i & mispredict & !flush_i → latch excp_addr_i and rob_id_i, go to REDIR, assert redir_valid_o next cycle.
  - REDIR:
    - redir_valid_o held with stable target/tag until redir_ready_i.
    - On redir_valid_o & redir_ready_i → WAIT_FLUSH, deassert redir_valid_o next cycle.
  - WAIT_FLUSH:
    - valid_i ops still write back, but generate neither update nor redirect.
    - flush_i → IDLE.
  - flush_i in any state forces IDLE and drops redir_valid_o next cycle, including a flush that coincides with redirect acceptance.
- Update FIFO:
  - Push when valid_i & is_cf_i & FSM==IDLE & !flush_i, including the mispredicting op itself.
  - Pop on upd_valid_o & upd_ready_i.
  - Simultaneous push/pop when full is allowed.
  - Push when full and no pop cannot occur: busy_o is asserted when full, and issue must honour it. The block must assert (simulation) if it does.
  - Pointers wrap modulo UPD_DEPTH.
  - flush_i does not clear the FIFO: entries are from older, committed-path ops.
- busy_o is combinational from registered state only.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds two outputs:
  - stat_branches_o[31:0]: counts FIFO pushes.
  - stat_mispred_o[31:0]: counts IDLE→REDIR transitions.
- Both counters reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Correct prediction: cond branch pc=0x100, taken, excp_addr=0x480, pred_taken=1, pred_target=0x480
  → no redirect; upd_valid_o with pc=0x100, target=0x480, taken=1, type=00 next cycle.
- Direction mispredict: brnch_res=0, excp_addr=0x404, pred_taken=1, rob_id=5, redir_ready_i held 0 for 3 cycles
  → redir_valid_o=1 with target 0x404 / rob 5, stable for 4 cycles; WAIT_FLUSH after acceptance.
- Squash: in WAIT_FLUSH issue jal rob=7 with wr_en, result=0x20C
  → wb pulse rob 7, data 0x20C; no FIFO push; flush_i returns FSM to IDLE.
- Target mispredict on ret: type=11, excp_addr=0x8000, pred_target=0x8004
  → redirect to 0x8000.
- FIFO backpressure: upd_ready_i=0, two correct branches
  → busy_o=1 after the second; raise upd_ready_i → entries drain in order, busy_o drops.
- Flush during REDIR coincident with redir_ready_i
  → FSM IDLE, redir_valid_o=0 next cycle; an async reset mid-redirect clears all outputs immediately.
